rename_stage: RTL and testbench



---
 rtl/rename_pkg.sv | 25 ++
 rtl/free_list.sv | 64 ++++++
 rtl/rename_stage.sv | 173 +++++++++++++++++
 tb/tb_rename_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared types and sizing for the two-wide rename stage and its free list.
package rename_pkg;
  localparam int ARCH_REGS = 32;
  localparam int PHY_REGS  = 64;
  localparam int FL_DEPTH  = PHY_REGS - ARCH_REGS;
  localparam int FL_IDX_W  = $clog2(FL_DEPTH);

  typedef logic [4:0]        areg_t;
  typedef logic [5:0]        preg_t;
  typedef logic [FL_IDX_W:0] flptr_t;

  typedef struct packed {
    areg_t rdst;
    areg_t src1;
    areg_t src2;
    preg_t phy;
    preg_t rsrc1;
    preg_t rsrc2;
    preg_t old_phy;
  } ds_slot_t;

  function automatic logic writes_reg(input areg_t r);
    return (r != 5'd0);
  endfunction
endpackage

// File: rtl/free_list.sv
// Circular list of free physical tags: two allocations at head, two releases at tail,
// and a retired head so a flush can rewind the speculative head in one cycle.
module free_list
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_alloc1,
  input  logic  i_alloc2,
  output preg_t o_tag0,
  output preg_t o_tag1,
  input  logic  i_free1,
  input  preg_t i_free1_tag,
  input  logic  i_free2,
  input  preg_t i_free2_tag,
  input  logic  i_flush,
  output logic  o_ge2
);
  preg_t  r_fl [FL_DEPTH];
  flptr_t r_head;
  flptr_t r_rhead;
  flptr_t r_tail;

  flptr_t     w_head1;
  flptr_t     w_tail1;
  flptr_t     w_count;
  flptr_t     w_rhead_nxt;
  logic [1:0] w_nalloc;
  logic [1:0] w_nfree;

  assign w_nalloc    = {1'b0, i_alloc1} + {1'b0, i_alloc2};
  assign w_nfree     = {1'b0, i_free1} + {1'b0, i_free2};
  assign w_head1     = r_head + flptr_t'(1'b1);
  assign w_tail1     = r_tail + flptr_t'(i_free1);
  assign w_rhead_nxt = r_rhead + flptr_t'(w_nfree);
  assign w_count     = r_tail - r_head;

  assign o_tag0 = r_fl[r_head[FL_IDX_W-1:0]];
  assign o_tag1 = r_fl[w_head1[FL_IDX_W-1:0]];
  // Allocation is gated on the count before this cycle's releases land.
  assign o_ge2  = (w_count >= flptr_t'(2'd2));

  // Pointer and storage update; flush rewinds head to the retired head including this cycle's commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_fl[i] <= preg_t'(ARCH_REGS + i);
      end
      r_head  <= '0;
      r_rhead <= '0;
      r_tail  <= flptr_t'(FL_DEPTH);
    end else begin
      if (i_free1) begin
        r_fl[r_tail[FL_IDX_W-1:0]] <= i_free1_tag;
      end
      if (i_free2) begin
        r_fl[w_tail1[FL_IDX_W-1:0]] <= i_free2_tag;
      end
      r_tail  <= r_tail + flptr_t'(w_nfree);
      r_rhead <= w_rhead_nxt;
      r_head  <= i_flush ? w_rhead_nxt : (r_head + flptr_t'(w_nalloc));
    end
  end
endmodule

// File: rtl/rename_stage.sv
// Two-wide rename: speculative and retirement RATs, free-list allocation and the
// registered group handed to dispatch.
module rename_stage
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  ID_Valid,
  input  logic  ID_Inst2_Valid,
  output logic  ID_Ready,
  input  areg_t ID_Inst1_Rdst,
  input  areg_t ID_Inst1_Src1,
  input  areg_t ID_Inst1_Src2,
  input  areg_t ID_Inst2_Rdst,
  input  areg_t ID_Inst2_Src1,
  input  areg_t ID_Inst2_Src2,
  output logic  DS_Valid,
  output logic  DS_Inst2_Valid,
  input  logic  DS_Ready,
  output areg_t DS_Inst1_Rdst,
  output areg_t DS_Inst1_Src1,
  output areg_t DS_Inst1_Src2,
  output areg_t DS_Inst2_Rdst,
  output areg_t DS_Inst2_Src1,
  output areg_t DS_Inst2_Src2,
  output preg_t DS_Inst1_Phy,
  output preg_t DS_Inst1_RSrc1,
  output preg_t DS_Inst1_RSrc2,
  output preg_t DS_Inst1_OldPhy,
  output preg_t DS_Inst2_Phy,
  output preg_t DS_Inst2_RSrc1,
  output preg_t DS_Inst2_RSrc2,
  output preg_t DS_Inst2_OldPhy,
  input  logic  CM_Inst1_En,
  input  areg_t CM_Inst1_Rdst,
  input  preg_t CM_Inst1_Phy,
  input  preg_t CM_Inst1_OldPhy,
  input  logic  CM_Inst2_En,
  input  areg_t CM_Inst2_Rdst,
  input  preg_t CM_Inst2_Phy,
  input  preg_t CM_Inst2_OldPhy,
  input  logic  FL_Flush
);
  preg_t    r_srat [ARCH_REGS];
  preg_t    r_rrat [ARCH_REGS];
  preg_t    w_rrat_nxt [ARCH_REGS];
  ds_slot_t r_ds1;
  ds_slot_t r_ds2;
  logic     r_ds_valid;
  logic     r_ds2_valid;

  logic  w_ge2;
  logic  w_accept;
  logic  w_alloc1;
  logic  w_alloc2;
  logic  w_cm1;
  logic  w_cm2;
  preg_t w_tag0;
  preg_t w_tag1;
  preg_t w_phy1;
  preg_t w_phy2;
  preg_t w_old1;
  preg_t w_old2;

  assign ID_Ready = !FL_Flush && (!r_ds_valid || DS_Ready) && w_ge2;
  assign w_accept = ID_Valid && ID_Ready;
  assign w_alloc1 = w_accept && writes_reg(ID_Inst1_Rdst);
  assign w_alloc2 = w_accept && ID_Inst2_Valid && writes_reg(ID_Inst2_Rdst);
  assign w_cm1    = CM_Inst1_En && writes_reg(CM_Inst1_Rdst);
  assign w_cm2    = CM_Inst2_En && writes_reg(CM_Inst2_Rdst);

  assign w_phy1 = w_alloc1 ? w_tag0 : 6'd0;
  assign w_phy2 = w_alloc2 ? (w_alloc1 ? w_tag1 : w_tag0) : 6'd0;
  assign w_old1 = r_srat[ID_Inst1_Rdst];
  // A same-group WAW hands Inst1's fresh tag to Inst2 as the mapping to release later.
  assign w_old2 = (w_alloc1 && (ID_Inst2_Rdst == ID_Inst1_Rdst)) ? w_phy1 : r_srat[ID_Inst2_Rdst];

  free_list u_free_list (
    .clk         (clk),
    .rst         (rst),
    .i_alloc1    (w_alloc1),
    .i_alloc2    (w_alloc2),
    .o_tag0      (w_tag0),
    .o_tag1      (w_tag1),
    .i_free1     (w_cm1),
    .i_free1_tag (CM_Inst1_OldPhy),
    .i_free2     (w_cm2),
    .i_free2_tag (CM_Inst2_OldPhy),
    .i_flush     (FL_Flush),
    .o_ge2       (w_ge2)
  );

  // Retirement RAT as it will stand after this cycle's commits (port 2 wins on a shared Rdst).
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      w_rrat_nxt[i] = (w_cm2 && (CM_Inst2_Rdst == areg_t'(i))) ? CM_Inst2_Phy :
                      (w_cm1 && (CM_Inst1_Rdst == areg_t'(i))) ? CM_Inst1_Phy : r_rrat[i];
    end
  end

  // Retirement RAT register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_rrat[i] <= preg_t'(i);
      end
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_rrat[i] <= w_rrat_nxt[i];
      end
    end
  end

  // Speculative RAT: restored from retirement state on flush, else Inst1 then Inst2 writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_srat[i] <= preg_t'(i);
      end
    end else if (FL_Flush) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_srat[i] <= w_rrat_nxt[i];
      end
    end else begin
      if (w_alloc1) begin
        r_srat[ID_Inst1_Rdst] <= w_phy1;
      end
      if (w_alloc2) begin
        r_srat[ID_Inst2_Rdst] <= w_phy2;
      end
    end
  end

  // Dispatch-facing output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ds_valid  <= 1'b0;
      r_ds2_valid <= 1'b0;
      r_ds1       <= '0;
      r_ds2       <= '0;
    end else if (FL_Flush) begin
      r_ds_valid  <= 1'b0;
      r_ds2_valid <= 1'b0;
    end else if (w_accept) begin
      r_ds_valid  <= 1'b1;
      r_ds2_valid <= ID_Inst2_Valid;
      r_ds1 <= '{rdst: ID_Inst1_Rdst, src1: ID_Inst1_Src1, src2: ID_Inst1_Src2, phy: w_phy1,
                 rsrc1: r_srat[ID_Inst1_Src1], rsrc2: r_srat[ID_Inst1_Src2], old_phy: w_old1};
      r_ds2 <= '{rdst: ID_Inst2_Rdst, src1: ID_Inst2_Src1, src2: ID_Inst2_Src2, phy: w_phy2,
                 rsrc1: r_srat[ID_Inst2_Src1], rsrc2: r_srat[ID_Inst2_Src2], old_phy: w_old2};
    end else if (DS_Ready) begin
      r_ds_valid  <= 1'b0;
      r_ds2_valid <= 1'b0;
    end
  end

  assign DS_Valid        = r_ds_valid;
  assign DS_Inst2_Valid  = r_ds2_valid;
  assign DS_Inst1_Rdst   = r_ds1.rdst;
  assign DS_Inst1_Src1   = r_ds1.src1;
  assign DS_Inst1_Src2   = r_ds1.src2;
  assign DS_Inst1_Phy    = r_ds1.phy;
  assign DS_Inst1_RSrc1  = r_ds1.rsrc1;
  assign DS_Inst1_RSrc2  = r_ds1.rsrc2;
  assign DS_Inst1_OldPhy = r_ds1.old_phy;
  assign DS_Inst2_Rdst   = r_ds2.rdst;
  assign DS_Inst2_Src1   = r_ds2.src1;
  assign DS_Inst2_Src2   = r_ds2.src2;
  assign DS_Inst2_Phy    = r_ds2.phy;
  assign DS_Inst2_RSrc1  = r_ds2.rsrc1;
  assign DS_Inst2_RSrc2  = r_ds2.rsrc2;
  assign DS_Inst2_OldPhy = r_ds2.old_phy;
endmodule

// File: tb/tb_rename_stage.sv
// Randomized bench for rename_stage against a queue-based model of rename, commit and flush.
module tb_rename_stage;
  import rename_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst, ID_Valid, ID_Inst2_Valid, ID_Ready, DS_Valid, DS_Inst2_Valid, DS_Ready, FL_Flush;
  areg_t ID_Inst1_Rdst, ID_Inst1_Src1, ID_Inst1_Src2, ID_Inst2_Rdst, ID_Inst2_Src1, ID_Inst2_Src2;
  areg_t DS_Inst1_Rdst, DS_Inst1_Src1, DS_Inst1_Src2, DS_Inst2_Rdst, DS_Inst2_Src1, DS_Inst2_Src2;
  preg_t DS_Inst1_Phy, DS_Inst1_RSrc1, DS_Inst1_RSrc2, DS_Inst1_OldPhy;
  preg_t DS_Inst2_Phy, DS_Inst2_RSrc1, DS_Inst2_RSrc2, DS_Inst2_OldPhy;
  logic  CM_Inst1_En, CM_Inst2_En;
  areg_t CM_Inst1_Rdst, CM_Inst2_Rdst;
  preg_t CM_Inst1_Phy, CM_Inst1_OldPhy, CM_Inst2_Phy, CM_Inst2_OldPhy;

  rename_stage dut (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .ID_Inst2_Valid(ID_Inst2_Valid), .ID_Ready(ID_Ready),
    .ID_Inst1_Rdst(ID_Inst1_Rdst), .ID_Inst1_Src1(ID_Inst1_Src1), .ID_Inst1_Src2(ID_Inst1_Src2),
    .ID_Inst2_Rdst(ID_Inst2_Rdst), .ID_Inst2_Src1(ID_Inst2_Src1), .ID_Inst2_Src2(ID_Inst2_Src2),
    .DS_Valid(DS_Valid), .DS_Inst2_Valid(DS_Inst2_Valid), .DS_Ready(DS_Ready),
    .DS_Inst1_Rdst(DS_Inst1_Rdst), .DS_Inst1_Src1(DS_Inst1_Src1), .DS_Inst1_Src2(DS_Inst1_Src2),
    .DS_Inst2_Rdst(DS_Inst2_Rdst), .DS_Inst2_Src1(DS_Inst2_Src1), .DS_Inst2_Src2(DS_Inst2_Src2),
    .DS_Inst1_Phy(DS_Inst1_Phy), .DS_Inst1_RSrc1(DS_Inst1_RSrc1), .DS_Inst1_RSrc2(DS_Inst1_RSrc2),
    .DS_Inst1_OldPhy(DS_Inst1_OldPhy), .DS_Inst2_Phy(DS_Inst2_Phy), .DS_Inst2_RSrc1(DS_Inst2_RSrc1),
    .DS_Inst2_RSrc2(DS_Inst2_RSrc2), .DS_Inst2_OldPhy(DS_Inst2_OldPhy),
    .CM_Inst1_En(CM_Inst1_En), .CM_Inst1_Rdst(CM_Inst1_Rdst), .CM_Inst1_Phy(CM_Inst1_Phy),
    .CM_Inst1_OldPhy(CM_Inst1_OldPhy), .CM_Inst2_En(CM_Inst2_En), .CM_Inst2_Rdst(CM_Inst2_Rdst),
    .CM_Inst2_Phy(CM_Inst2_Phy), .CM_Inst2_OldPhy(CM_Inst2_OldPhy), .FL_Flush(FL_Flush)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural maps, free tags as queues, in-flight writers in order.
  typedef struct { int rdst; int phy; int old; } rob_t;
  int   srat [32];
  int   rrat [32];
  int   spec_q[$];
  int   ret_q[$];
  rob_t rob[$];
  bit   m_dsv, m_ds2v;
  logic [38:0] m_slot1, m_slot2;

  int s_rst, s_idv, s_i2v, s_rd1, s_s11, s_s12, s_rd2, s_s21, s_s22, s_dsr, s_flush, s_ncm, s_junk;

  function automatic logic [38:0] pk(input int rd, input int a, input int b, input int p,
                                     input int ra, input int rb, input int o);
    return {rd[4:0], a[4:0], b[4:0], p[5:0], ra[5:0], rb[5:0], o[5:0]};
  endfunction

  function automatic logic [38:0] dut_slot1();
    return {DS_Inst1_Rdst, DS_Inst1_Src1, DS_Inst1_Src2, DS_Inst1_Phy, DS_Inst1_RSrc1, DS_Inst1_RSrc2, DS_Inst1_OldPhy};
  endfunction

  function automatic logic [38:0] dut_slot2();
    return {DS_Inst2_Rdst, DS_Inst2_Src1, DS_Inst2_Src2, DS_Inst2_Phy, DS_Inst2_RSrc1, DS_Inst2_RSrc2, DS_Inst2_OldPhy};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      srat[i] = i;
      rrat[i] = i;
    end
    spec_q.delete();
    for (int i = 0; i < 32; i++) spec_q.push_back(32 + i);
    ret_q = spec_q;
    rob.delete();
    m_dsv = 1'b0;
    m_ds2v = 1'b0;
    m_slot1 = '0;
    m_slot2 = '0;
  endtask

  task automatic set_idle();
    s_rst = 0; s_idv = 0; s_i2v = 0; s_dsr = 1; s_flush = 0; s_ncm = 0; s_junk = 0;
    s_rd1 = 0; s_s11 = 0; s_s12 = 0; s_rd2 = 0; s_s21 = 0; s_s22 = 0;
  endtask

  task automatic set_group(input int rd1, input int a1, input int b1, input int v2,
                           input int rd2, input int a2, input int b2);
    set_idle();
    s_idv = 1; s_i2v = v2;
    s_rd1 = rd1; s_s11 = a1; s_s12 = b1; s_rd2 = rd2; s_s21 = a2; s_s22 = b2;
  endtask

  // One clock: drive at negedge, check outputs and ID_Ready, then advance the model.
  task automatic cycle();
    bit exp_ready, acc;
    int nc, p1, p2, o1, o2;
    int cold [2];
    @(negedge clk);
    rst = (s_rst != 0); ID_Valid = (s_idv != 0); ID_Inst2_Valid = (s_i2v != 0);
    ID_Inst1_Rdst = 5'(s_rd1); ID_Inst1_Src1 = 5'(s_s11); ID_Inst1_Src2 = 5'(s_s12);
    ID_Inst2_Rdst = 5'(s_rd2); ID_Inst2_Src1 = 5'(s_s21); ID_Inst2_Src2 = 5'(s_s22);
    DS_Ready = (s_dsr != 0); FL_Flush = (s_flush != 0);
    nc = (s_ncm < rob.size()) ? s_ncm : rob.size();
    CM_Inst1_En = 1'b0; CM_Inst1_Rdst = 5'd0; CM_Inst1_Phy = 6'd0; CM_Inst1_OldPhy = 6'd0;
    CM_Inst2_En = 1'b0; CM_Inst2_Rdst = 5'd0; CM_Inst2_Phy = 6'd0; CM_Inst2_OldPhy = 6'd0;
    if (nc >= 1) begin
      CM_Inst1_En = 1'b1; CM_Inst1_Rdst = 5'(rob[0].rdst);
      CM_Inst1_Phy = 6'(rob[0].phy); CM_Inst1_OldPhy = 6'(rob[0].old);
    end else if (s_junk != 0) begin
      CM_Inst1_En = 1'b1; CM_Inst1_Phy = 6'($urandom); CM_Inst1_OldPhy = 6'($urandom);
    end
    if (nc >= 2) begin
      CM_Inst2_En = 1'b1; CM_Inst2_Rdst = 5'(rob[1].rdst);
      CM_Inst2_Phy = 6'(rob[1].phy); CM_Inst2_OldPhy = 6'(rob[1].old);
    end else if (s_junk != 0) begin
      CM_Inst2_En = 1'b1; CM_Inst2_Phy = 6'($urandom); CM_Inst2_OldPhy = 6'($urandom);
    end
    #1;
    check_val("ds_valid", DS_Valid, m_dsv);
    check_val("ds_inst2_valid", DS_Inst2_Valid, m_ds2v);
    if (m_dsv) check_val("ds_slot1", dut_slot1(), m_slot1);
    if (m_ds2v) check_val("ds_slot2", dut_slot2(), m_slot2);
    exp_ready = (s_flush == 0) && (!m_dsv || s_dsr != 0) && (spec_q.size() >= 2);
    check_val("id_ready", ID_Ready, exp_ready);
    if (s_rst != 0) begin
      model_reset();
      return;
    end
    acc = (s_idv != 0) && exp_ready;
    for (int k = 0; k < nc; k++) begin
      cold[k] = rob[0].old;
      rrat[rob[0].rdst] = rob[0].phy;
      void'(ret_q.pop_front());
      ret_q.push_back(rob[0].old);
      void'(rob.pop_front());
    end
    if (s_flush != 0) begin
      for (int i = 0; i < 32; i++) srat[i] = rrat[i];
      spec_q = ret_q;
      rob.delete();
      m_dsv = 1'b0;
      m_ds2v = 1'b0;
    end else begin
      if (acc) begin
        p1 = (s_rd1 != 0) ? spec_q.pop_front() : 0;
        p2 = (s_i2v != 0 && s_rd2 != 0) ? spec_q.pop_front() : 0;
        o1 = srat[s_rd1];
        o2 = (s_rd1 != 0 && s_rd2 == s_rd1) ? p1 : srat[s_rd2];
        m_slot1 = pk(s_rd1, s_s11, s_s12, p1, srat[s_s11], srat[s_s12], o1);
        m_slot2 = pk(s_rd2, s_s21, s_s22, p2, srat[s_s21], srat[s_s22], o2);
        if (s_rd1 != 0) begin
          rob.push_back('{s_rd1, p1, o1});
          srat[s_rd1] = p1;
        end
        if (s_i2v != 0 && s_rd2 != 0) begin
          rob.push_back('{s_rd2, p2, o2});
          srat[s_rd2] = p2;
        end
        m_dsv = 1'b1;
        m_ds2v = (s_i2v != 0);
      end else if (s_dsr != 0) begin
        m_dsv = 1'b0;
        m_ds2v = 1'b0;
      end
      for (int k = 0; k < nc; k++) spec_q.push_back(cold[k]);
    end
  endtask

  task automatic do_reset();
    set_group(1, 2, 3, 1, 4, 5, 6);
    s_rst = 1; s_flush = 1; s_ncm = 2;
    cycle();
    set_idle();
  endtask

  function automatic int rsel();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
  endfunction

  initial begin
    set_idle();
    rst = 1'b1; ID_Valid = 1'b0; ID_Inst2_Valid = 1'b0; DS_Ready = 1'b1; FL_Flush = 1'b0;
    ID_Inst1_Rdst = 5'd0; ID_Inst1_Src1 = 5'd0; ID_Inst1_Src2 = 5'd0;
    ID_Inst2_Rdst = 5'd0; ID_Inst2_Src1 = 5'd0; ID_Inst2_Src2 = 5'd0;
    CM_Inst1_En = 1'b0; CM_Inst1_Rdst = 5'd0; CM_Inst1_Phy = 6'd0; CM_Inst1_OldPhy = 6'd0;
    CM_Inst2_En = 1'b0; CM_Inst2_Rdst = 5'd0; CM_Inst2_Phy = 6'd0; CM_Inst2_OldPhy = 6'd0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_valid", {DS_Valid, DS_Inst2_Valid}, 2'b00);
    check_val("rst_slot1", dut_slot1(), 39'd0);
    check_val("rst_slot2", dut_slot2(), 39'd0);
    check_val("rst_ready", ID_Ready, 1'b1);

    // Basic two-writer group, sources see pre-group mappings.
    set_group(1, 2, 3, 1, 4, 1, 5); cycle();
    set_idle(); cycle();
    check_val("tp1_slot1", dut_slot1(), pk(1, 2, 3, 32, 2, 3, 1));
    check_val("tp1_slot2", dut_slot2(), pk(4, 1, 5, 33, 1, 5, 4));

    // Same-group WAW on r7, then a reader of r7.
    do_reset();
    set_group(7, 1, 2, 1, 7, 3, 4); cycle();
    set_group(9, 7, 0, 0, 0, 0, 0); cycle();
    check_val("waw_old2", DS_Inst2_OldPhy, 6'd32);
    set_idle(); cycle();
    check_val("waw_rsrc", DS_Inst1_RSrc1, 6'd33);

    // Both slots write r0: no allocation.
    do_reset();
    set_group(0, 1, 2, 1, 0, 3, 4); cycle();
    set_group(1, 0, 0, 0, 0, 0, 0); cycle();
    check_val("r0_phys", {DS_Inst1_Phy, DS_Inst2_Phy}, 12'd0);
    set_idle(); cycle();
    check_val("r0_head", DS_Inst1_Phy, 6'd32);

    // Drain the free list, then release one and two tags.
    do_reset();
    for (int g = 0; g < 16; g++) begin
      set_group(1 + (g % 31), 0, 0, 1, 1 + ((g + 5) % 31), 0, 0);
      cycle();
    end
    set_idle(); cycle();
    check_val("fl_empty_stall", ID_Ready, 1'b0);
    set_idle(); s_ncm = 1; cycle();
    set_idle(); cycle();
    check_val("fl_one_stall", ID_Ready, 1'b0);
    set_idle(); s_ncm = 1; cycle();
    set_idle(); cycle();
    check_val("fl_two_ready", ID_Ready, 1'b1);

    // Commit then flush restores r1 and rewinds head.
    do_reset();
    set_group(1, 0, 0, 0, 0, 0, 0); cycle();
    set_group(1, 0, 0, 0, 0, 0, 0); s_ncm = 1; cycle();
    set_idle(); s_flush = 1; cycle();
    set_group(2, 1, 0, 0, 0, 0, 0); cycle();
    set_idle(); cycle();
    check_val("flush_slot1", dut_slot1(), pk(2, 1, 0, 33, 32, 0, 2));

    // Dispatch backpressure holds the group and blocks allocation.
    do_reset();
    set_group(3, 4, 5, 0, 0, 0, 0); cycle();
    for (int k = 0; k < 3; k++) begin
      set_group(6, 0, 0, 0, 0, 0, 0); s_dsr = 0; cycle();
      check_val("hold_ready", ID_Ready, 1'b0);
      check_val("hold_slot1", dut_slot1(), pk(3, 4, 5, 32, 4, 5, 3));
    end
    set_group(6, 0, 0, 0, 0, 0, 0); cycle();
    set_idle(); cycle();
    check_val("hold_next_phy", DS_Inst1_Phy, 6'd33);

    // Random traffic with commits, flushes and occasional resets.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      set_group(rsel(), rsel(), rsel(), int'($urandom_range(0, 1)), rsel(), rsel(), rsel());
      s_idv   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s_dsr   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s_flush = ($urandom_range(0, 39) == 0) ? 1 : 0;
      s_ncm   = int'($urandom_range(0, 2));
      s_junk  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      s_rst   = ($urandom_range(0, 699) == 0) ? 1 : 0;
      if (s_rst != 0) s_flush = 1;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
